// File: rtl/clk_src_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_src_ctrl_pkg
// Shared definitions for the clock-source control block: clk_cpu speed
// encodings, default PRR location and bit positions, divider reload value and
// the counter-width helpers derived from the speed selection.
// -----------------------------------------------------------------------------
package clk_src_ctrl_pkg;

  // clk_cpu speed relative to the 16MHz reference; encoding 3 is illegal.
  typedef enum logic [1:0] {
    CLK_SEL_16MHZ = 2'd0,
    CLK_SEL_32MHZ = 2'd1,
    CLK_SEL_64MHZ = 2'd2
  } clk_sel_e;

  // Default PRR location; addresses at or above DATA_SPACE_BASE are only
  // reachable through the data-space (ramadr/dm_sel) path.
  localparam logic [7:0] PRR_ADDR_DEFAULT = 8'h64;
  localparam logic [7:0] DATA_SPACE_BASE  = 8'h60;

  // PRR bit that stops the internal oscillator.
  localparam int PRINTOSC_BIT_DEFAULT = 4;

  // 128kHz divider reload: period is value+1 en16mhz ticks.
  localparam logic [6:0] CLKCNT125_MAX_DEFAULT = 7'd124;

  // clk_cpu cycles per 1MHz tick are 2^(sel+4).
  function automatic int clkcnt_width(input clk_sel_e sel);
    return int'(sel) + 4;
  endfunction

  // Lock must be stable for about 2^(sel+6) clk_ref cycles.
  function automatic int lock_cnt_width(input clk_sel_e sel);
    return int'(sel) + 6;
  endfunction

endpackage

// File: rtl/clk_src_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_src_ctrl_if
// AVR core I/O / data-space bus as seen by the clock-source control block.
//   adr[5:0]     I/O address          iore/iowe   I/O read/write strobes
//   ramadr[7:0]  data-space address   ramre/ramwe data-space read/write strobes
//   dm_sel       data-space select    dbus_in     write data
//   dbus_out     read data from PRR   io_out_en   read-data valid
// master = core side, slave = this block.
// -----------------------------------------------------------------------------
interface clk_src_ctrl_if;
  logic [5:0] adr;
  logic       iore;
  logic       iowe;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic       dm_sel;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       io_out_en;

  modport master (
    output adr, iore, iowe, ramadr, ramre, ramwe, dm_sel, dbus_in,
    input  dbus_out, io_out_en
  );

  modport slave (
    input  adr, iore, iowe, ramadr, ramre, ramwe, dm_sel, dbus_in,
    output dbus_out, io_out_en
  );
endinterface

// File: rtl/clk_src_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// clk_src_ctrl_sync2
// Two-flop synchronizer for a single asynchronous level.
//   clk  in  destination clock
//   d    in  asynchronous input
//   q    out synchronized level (two clk edges of latency)
// No reset: it sits in front of logic that must work before any reset exists.
// -----------------------------------------------------------------------------
module clk_src_ctrl_sync2 (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end
endmodule

// File: rtl/clk_src_ctrl.sv
// -----------------------------------------------------------------------------
// clk_src_ctrl
// Control/monitor logic around the clock sources: PRR (oscillator gating),
// 16MHz/1MHz/128kHz timer enables, internal-oscillator /1024 divider, PLL lock
// filter and power-on reset.
//   clk_cpu, core_rstn  CPU clock and its async active-low reset
//   clk_ref             16MHz reference; lock filter and POR run on it
//   clk_intosc          internal oscillator, drives the /1024 divider
//   pll_locked          asynchronous PLL lock
//   bus                 core I/O + data-space bus (slave side)
//   osc_ena             internal oscillator enable (= !PRINTOSC)
//   intosc_div1024      clk_intosc / 1024, 50% duty
//   en16mhz/en1mhz/en128khz  single-cycle enables, clk_cpu domain
//   pwr_on_nrst         power-on reset, active low, clk_ref domain
// CLOCK_SELECT must not be 3.
// -----------------------------------------------------------------------------
module clk_src_ctrl
  import clk_src_ctrl_pkg::*;
#(
  parameter clk_sel_e   CLOCK_SELECT  = CLK_SEL_16MHZ,
  parameter logic [7:0] PRR_ADDR      = PRR_ADDR_DEFAULT,
  parameter int         PRINTOSC_BIT  = PRINTOSC_BIT_DEFAULT,
  parameter logic [6:0] CLKCNT125_MAX = CLKCNT125_MAX_DEFAULT
) (
  input  logic            clk_cpu,
  input  logic            core_rstn,
  input  logic            clk_ref,
  input  logic            clk_intosc,
  input  logic            pll_locked,
  clk_src_ctrl_if.slave   bus,
  output logic            osc_ena,
  output logic            intosc_div1024,
  output logic            en16mhz,
  output logic            en1mhz,
  output logic            en128khz,
  output logic            pwr_on_nrst
);

  localparam int         CS       = int'(CLOCK_SELECT);
  localparam int         CNT_W    = clkcnt_width(CLOCK_SELECT);
  localparam int         LCNT_W   = lock_cnt_width(CLOCK_SELECT);
  localparam logic [7:0] PRR_MASK = 8'(1) << PRINTOSC_BIT;

  // ---------------------------------------------------------------------------
  // PRR decode and register
  // ---------------------------------------------------------------------------
  logic       data_path;
  logic       prr_sel;
  logic       prr_we;
  logic       prr_re;
  logic [7:0] prr;

  assign data_path = (PRR_ADDR >= DATA_SPACE_BASE);

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    prr_sel = 1'b0;
    prr_we  = 1'b0;
    prr_re  = 1'b0;
    if (data_path) begin
      prr_sel = bus.dm_sel && (bus.ramadr == PRR_ADDR);
      prr_we  = bus.ramwe;
      prr_re  = bus.ramre;
    end else begin
      prr_sel = (bus.adr == PRR_ADDR[5:0]);
      prr_we  = bus.iowe;
      prr_re  = bus.iore;
    end
  end

  // Unimplemented PRR bits are masked on write, so they stay constant 0 and
  // synthesis drops those flops.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_cpu or negedge core_rstn) begin
    if (!core_rstn) begin
      prr <= '0;
    end else if (prr_sel && prr_we) begin
      prr <= bus.dbus_in & PRR_MASK;
    end
  end

  assign bus.dbus_out  = prr_sel ? prr : 8'h00;
  assign bus.io_out_en = prr_sel && prr_re;
  assign osc_ena       = ~prr[PRINTOSC_BIT];

  // ---------------------------------------------------------------------------
  // 1MHz / 16MHz enables: clkcnt counts down through 2^CNT_W states
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] clkcnt;

  always_ff @(posedge clk_cpu or negedge core_rstn) begin
    if (!core_rstn) begin
      clkcnt <= '0;
      en1mhz <= 1'b0;
    end else if (clkcnt == '0) begin
      clkcnt <= '1;
      en1mhz <= 1'b1;
    end else begin
      clkcnt <= clkcnt - CNT_W'(1);
      en1mhz <= 1'b0;
    end
  end

  // At 16MHz every clk_cpu cycle is a 16MHz tick; faster clocks use the low
  // clkcnt bits as a 2^CS prescaler.
  if (CS == 0) begin : g_en16_tied
    assign en16mhz = 1'b1;
  end else begin : g_en16_reg
    always_ff @(posedge clk_cpu or negedge core_rstn) begin
      if (!core_rstn) en16mhz <= 1'b0;
      else            en16mhz <= ~|clkcnt[CS-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // 128kHz enable: divide the 16MHz ticks by CLKCNT125_MAX+1
  // ---------------------------------------------------------------------------
  logic [6:0] clkcnt125;

  always_ff @(posedge clk_cpu or negedge core_rstn) begin
    if (!core_rstn) begin
      clkcnt125 <= '0;
      en128khz  <= 1'b0;
    end else if (en16mhz) begin
      clkcnt125 <= (clkcnt125 == '0) ? CLKCNT125_MAX : clkcnt125 - 7'd1;
      en128khz  <= (clkcnt125 == '0);
    end else begin
      en128khz  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Internal oscillator /1024
  // ---------------------------------------------------------------------------
  logic [9:0] osc_cnt;

  // NOTE: this counter and the lock filter have no reset: they run from
  // power-up before any reset is available and rely on the flops powering up
  // at 0; a free-running divider has no state that needs defining anyway.
  always_ff @(posedge clk_intosc) begin
    osc_cnt <= osc_cnt + 10'd1;
  end

  assign intosc_div1024 = osc_cnt[9];

  // ---------------------------------------------------------------------------
  // PLL lock filter (clk_ref domain)
  // ---------------------------------------------------------------------------
  logic              lk_s;
  logic              lk_p;
  logic              lk_f;
  logic [LCNT_W-1:0] lcnt;

  clk_src_ctrl_sync2 u_lock_sync (
    .clk (clk_ref),
    .d   (pll_locked),
    .q   (lk_s)
  );

  // Any change of the synchronized level restarts the count, so lk_f only
  // follows a level that stayed put for the full counter range.
  always_ff @(posedge clk_ref) begin
    lk_p <= lk_s;
    if (lk_p != lk_s) begin
      lcnt <= '0;
    end else if (&lcnt) begin
      lk_f <= lk_s;
    end else begin
      lcnt <= lcnt + LCNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Power-on reset: asserts immediately on loss of lock, releases two clk_ref
  // cycles after the filtered lock rises.
  // ---------------------------------------------------------------------------
  logic r1;

  always_ff @(posedge clk_ref or negedge lk_f) begin
    if (!lk_f) begin
      r1          <= 1'b0;
      pwr_on_nrst <= 1'b0;
    end else begin
      r1          <= 1'b1;
      pwr_on_nrst <= r1;
    end
  end

endmodule

// File: tb/tb_clk_src_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_src_ctrl
// Scoreboard bench for clk_src_ctrl. dut0 runs at CLOCK_SELECT=0, dut1 at
// CLOCK_SELECT=2; both share clocks, core_rstn, clk_intosc and pll_locked.
// Expected values are pushed to a queue as stimulus is applied and popped when
// the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_clk_src_ctrl;
  import clk_src_ctrl_pkg::*;

  // Expected periods derived from the clocking scheme, not from the RTL.
  localparam int EN1_PER0   = 1 << (0 + 4);
  localparam int EN128_PER0 = 125;
  localparam int EN16_PER1  = 1 << 2;
  localparam int EN1_PER1   = 1 << (2 + 4);
  localparam int POR_LAT0   = 2 + 1 + 63 + 1 + 2;
  localparam int LKF_FALL0  = 2 + 1 + 63 + 1;

  logic clk_cpu    = 1'b0;
  logic clk_ref    = 1'b0;
  logic core_rstn  = 1'b0;
  logic clk_intosc = 1'b0;
  logic pll_locked = 1'b0;

  always #5  clk_cpu = ~clk_cpu;
  always #10 clk_ref = ~clk_ref;

  clk_src_ctrl_if bus0 ();
  clk_src_ctrl_if bus1 ();

  logic osc_ena0, div0, en16mhz0, en1mhz0, en128khz0, por0;
  logic osc_ena1, div1, en16mhz1, en1mhz1, en128khz1, por1;

  clk_src_ctrl #(.CLOCK_SELECT(CLK_SEL_16MHZ)) dut0 (
    .clk_cpu        (clk_cpu),
    .core_rstn      (core_rstn),
    .clk_ref        (clk_ref),
    .clk_intosc     (clk_intosc),
    .pll_locked     (pll_locked),
    .bus            (bus0),
    .osc_ena        (osc_ena0),
    .intosc_div1024 (div0),
    .en16mhz        (en16mhz0),
    .en1mhz         (en1mhz0),
    .en128khz       (en128khz0),
    .pwr_on_nrst    (por0)
  );

  clk_src_ctrl #(.CLOCK_SELECT(CLK_SEL_64MHZ)) dut1 (
    .clk_cpu        (clk_cpu),
    .core_rstn      (core_rstn),
    .clk_ref        (clk_ref),
    .clk_intosc     (clk_intosc),
    .pll_locked     (pll_locked),
    .bus            (bus1),
    .osc_ena        (osc_ena1),
    .intosc_div1024 (div1),
    .en16mhz        (en16mhz1),
    .en1mhz         (en1mhz1),
    .en128khz       (en128khz1),
    .pwr_on_nrst    (por1)
  );

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  typedef enum int {P_EN1_0, P_EN128_0, P_EN16_0, P_EN1_1, P_EN16_1} pulse_e;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  function automatic logic sig(input pulse_e sel);
    case (sel)
      P_EN1_0:   return en1mhz0;
      P_EN128_0: return en128khz0;
      P_EN16_0:  return en16mhz0;
      P_EN1_1:   return en1mhz1;
      default:   return en16mhz1;
    endcase
  endfunction

  // Negedges of clk_cpu until the selected enable is seen high; -1 on timeout.
  task automatic cycles_to_pulse(input pulse_e sel, input int budget,
                                 output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk_cpu);
      if (sig(sel)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic measure_period(input string tag, input pulse_e sel,
                                input int exp_per);
    int n;
    cycles_to_pulse(sel, 2 * exp_per + 10, n);  // align on a pulse
    push_exp(tag, 32'(exp_per));
    cycles_to_pulse(sel, 2 * exp_per + 10, n);
    pop_cmp(32'(n));
  endtask

  task automatic bus0_write(input logic dm, input logic [7:0] ra,
                            input logic [5:0] a, input logic rwe,
                            input logic iwe, input logic [7:0] d);
    @(negedge clk_cpu);
    bus0.dm_sel  = dm;
    bus0.ramadr  = ra;
    bus0.adr     = a;
    bus0.ramwe   = rwe;
    bus0.iowe    = iwe;
    bus0.dbus_in = d;
    @(negedge clk_cpu);
    bus0.ramwe   = 1'b0;
    bus0.iowe    = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int low_cnt;

    {bus0.adr, bus0.iore, bus0.iowe, bus0.ramadr} = '0;
    {bus0.ramre, bus0.ramwe, bus0.dm_sel, bus0.dbus_in} = '0;
    {bus1.adr, bus1.iore, bus1.iowe, bus1.ramadr} = '0;
    {bus1.ramre, bus1.ramwe, bus1.dm_sel, bus1.dbus_in} = '0;

    // Reset state
    #22;
    push_exp("rst_en1mhz0", 0);   pop_cmp(32'(en1mhz0));
    push_exp("rst_en128khz0", 0); pop_cmp(32'(en128khz0));
    push_exp("rst_en16mhz0", 1);  pop_cmp(32'(en16mhz0));
    push_exp("rst_en16mhz1", 0);  pop_cmp(32'(en16mhz1));
    push_exp("rst_osc_ena0", 1);  pop_cmp(32'(osc_ena0));
    push_exp("rst_osc_ena1", 1);  pop_cmp(32'(osc_ena1));
    push_exp("rst_dbus_out0", 0); pop_cmp(32'(bus0.dbus_out));
    push_exp("rst_io_out_en1", 0); pop_cmp(32'(bus1.io_out_en));
    push_exp("rst_por0", 0);      pop_cmp(32'(por0));

    // Enables at CLOCK_SELECT=0
    @(negedge clk_cpu);
    core_rstn = 1'b1;
    push_exp("en1mhz0_first", 1);
    cycles_to_pulse(P_EN1_0, 40, n);
    pop_cmp(32'(n));
    push_exp("en128khz0_first", 1); pop_cmp(32'(en128khz0));
    measure_period("en1mhz0_period", P_EN1_0, EN1_PER0);
    measure_period("en1mhz0_period2", P_EN1_0, EN1_PER0);
    measure_period("en128khz0_period", P_EN128_0, EN128_PER0);
    low_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_cpu);
      if (!en16mhz0) low_cnt++;
    end
    push_exp("en16mhz0_low_cycles", 0); pop_cmp(32'(low_cnt));

    // PRR through the data-space path
    bus0_write(1'b1, 8'h64, 6'h00, 1'b1, 1'b0, 8'hFF);
    push_exp("prr_wr_osc_ena", 0); pop_cmp(32'(osc_ena0));
    push_exp("prr_sel_no_rd_dbus", 8'h10); pop_cmp(32'(bus0.dbus_out));
    push_exp("prr_sel_no_rd_oe", 0); pop_cmp(32'(bus0.io_out_en));
    bus0.ramre = 1'b1;
    #1;
    push_exp("prr_rd_dbus", 8'h10); pop_cmp(32'(bus0.dbus_out));
    push_exp("prr_rd_oe", 1);       pop_cmp(32'(bus0.io_out_en));
    bus0.ramadr = 8'h65;
    #1;
    push_exp("rd_0x65_dbus", 0); pop_cmp(32'(bus0.dbus_out));
    push_exp("rd_0x65_oe", 0);   pop_cmp(32'(bus0.io_out_en));
    bus0.ramre = 1'b0;
    // I/O path alias and unselected data write must be ignored
    bus0_write(1'b0, 8'h00, 6'h24, 1'b0, 1'b1, 8'h00);
    push_exp("io_alias_ignored", 0); pop_cmp(32'(osc_ena0));
    bus0_write(1'b0, 8'h64, 6'h00, 1'b1, 1'b0, 8'h00);
    push_exp("no_dm_sel_ignored", 0); pop_cmp(32'(osc_ena0));
    bus0_write(1'b1, 8'h64, 6'h00, 1'b1, 1'b0, 8'hEF);
    push_exp("prr_clr_osc_ena", 1); pop_cmp(32'(osc_ena0));
    push_exp("prr_clr_dbus", 0);    pop_cmp(32'(bus0.dbus_out));
    bus0_write(1'b1, 8'h64, 6'h00, 1'b1, 1'b0, 8'h10);
    push_exp("prr_set_again", 0);   pop_cmp(32'(osc_ena0));
    bus0.dm_sel = 1'b0;
    bus0.ramadr = 8'h00;

    // Internal oscillator divider from power-up
    for (int i = 1; i <= 1024; i++) begin
      #3 clk_intosc = 1'b1;
      #1;
      if (i == 511 || i == 512 || i == 1023 || i == 1024) begin
        push_exp($sformatf("div0_edge%0d", i), 32'((i / 512) % 2));
        pop_cmp(32'(div0));
        push_exp($sformatf("div1_edge%0d", i), 32'((i / 512) % 2));
        pop_cmp(32'(div1));
      end
      #2 clk_intosc = 1'b0;
    end

    // Lock rise -> POR release
    @(posedge clk_ref);
    #1 pll_locked = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clk_ref);
      #1;
      if (k == 1 || k == POR_LAT0 - 1 || k == POR_LAT0 || k == 75) begin
        push_exp($sformatf("por_rise_k%0d", k), 32'(k >= POR_LAT0));
        pop_cmp(32'(por0));
      end
      if (k == POR_LAT0) begin
        push_exp("por1_slower", 0); pop_cmp(32'(por1));
      end
    end

    // Short low glitch is filtered
    @(posedge clk_ref);
    #1 pll_locked = 1'b0;
    repeat (40) @(posedge clk_ref);
    #1 pll_locked = 1'b1;
    low_cnt = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk_ref);
      #1;
      if (!por0) low_cnt++;
    end
    push_exp("glitch_por_low_cycles", 0); pop_cmp(32'(low_cnt));

    // Long loss of lock -> POR asserts, then releases again
    @(posedge clk_ref);
    #1 pll_locked = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk_ref);
      #1;
      if (k == LKF_FALL0 - 1 || k == LKF_FALL0) begin
        push_exp($sformatf("por_fall_k%0d", k), 32'(k < LKF_FALL0));
        pop_cmp(32'(por0));
      end
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= POR_LAT0; k++) begin
      @(posedge clk_ref);
      #1;
      if (k >= POR_LAT0 - 1) begin
        push_exp($sformatf("por_relock_k%0d", k), 32'(k >= POR_LAT0));
        pop_cmp(32'(por0));
      end
    end

    // CLOCK_SELECT=2 enables and mid-count core reset
    measure_period("en16mhz1_period", P_EN16_1, EN16_PER1);
    measure_period("en1mhz1_period", P_EN1_1, EN1_PER1);
    repeat (23) @(negedge clk_cpu);
    core_rstn = 1'b0;
    #1;
    push_exp("midrst_en16mhz1", 0); pop_cmp(32'(en16mhz1));
    push_exp("midrst_osc_ena0", 1); pop_cmp(32'(osc_ena0));
    @(negedge clk_cpu);
    core_rstn = 1'b1;
    push_exp("restart_en1mhz1", 1);
    cycles_to_pulse(P_EN1_1, 100, n);
    pop_cmp(32'(n));
    push_exp("restart_en16mhz1", 1);  pop_cmp(32'(en16mhz1));
    push_exp("restart_en1mhz0", 1);   pop_cmp(32'(en1mhz0));
    push_exp("restart_en128khz0", 1); pop_cmp(32'(en128khz0));
    push_exp("restart_en16_next", 32'(EN16_PER1));
    cycles_to_pulse(P_EN16_1, 20, n);
    pop_cmp(32'(n));
    push_exp("restart_en1_next", 32'(EN1_PER1 - EN16_PER1));
    cycles_to_pulse(P_EN1_1, 200, n);
    pop_cmp(32'(n));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
